// File: rtl/ahb_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge: decodes a window into NSLV one-hot APB selects.
// Latency: read = 2 wait states, write = 3 wait states, +1 per pready-low ACCESS cycle.
// Backpressure: hreadyout is low while an APB transfer or ERR1 is in progress; one transfer in flight.
//
// Ports:
//   hclk, hreset                       clock, asynchronous active-high reset
//   hsel, hreadyin, htrans, hwrite,    AHB address phase
//   haddr, hwdata                      (hwdata in the first data-phase cycle)
//   hreadyout, hresp, hrdata           AHB response (hresp 01 = ERROR, two cycles)
//   pselx, penable, pwrite, paddr,     APB3 master request
//   pwdata
//   prdata, pready, pslverr            APB3 slave response
module ahb_apb3_bridge #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 NSLV      = 3,
  parameter logic [ADDR_W-1:0]  BASE      = ADDR_W'(32'h8000_0000),
  parameter int                 SLV_SHIFT = 26,
  parameter int                 TIMEOUT   = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hreadyin,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [NSLV-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  // A zero TIMEOUT would give a zero-width counter; keep one bit so the logic stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WWAIT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  sel_idx;
  logic [NSLV-1:0]   sel_oh;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] off_idx;
  logic              active;
  logic              hit;
  logic              can_accept;
  logic              timeout_hit;
  logic              unused_htrans0;

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  assign active         = hsel & hreadyin & htrans[1];
  assign unused_htrans0 = htrans[0];

  assign off     = haddr - BASE;
  assign off_idx = off >> SLV_SHIFT;
  assign hit     = (haddr >= BASE) && (off_idx < ADDR_W'(NSLV));

  // ERR2 already drives hreadyout=1, so it accepts a new address phase exactly like IDLE.
  assign can_accept = (state == S_IDLE) || (state == S_ERR2);

  // Fires on the ACCESS cycle that would make the count reach TIMEOUT; pready is
  // checked first in the next-state logic, so a ready slave still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Straight from IDLE/ERR2 into SETUP the index comes from the live decode;
  // after WWAIT it comes from the captured copy.
  assign sel_idx = can_accept ? off_idx[IDX_W-1:0] : idx_q;
  assign sel_oh  = NSLV'(1) << sel_idx;

  // Moore outputs: depend on state only.
  assign hreadyout = can_accept;
  assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_ERR2: begin
        if (active) begin
          if (hit) state_nxt = hwrite ? S_WWAIT : S_SETUP;
          else     state_nxt = S_ERR1;
        end
      end
      S_WWAIT:  state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (pready)           state_nxt = pslverr ? S_ERR1 : S_IDLE;
        else if (timeout_hit) state_nxt = S_ERR1;
        else                  state_nxt = S_ACCESS;
      end
      S_ERR1:   state_nxt = S_ERR2;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      cnt     <= '0;
      pselx   <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      hrdata  <= '0;
    end else begin
      state <= state_nxt;

      if (can_accept && active && hit) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        idx_q  <= off_idx[IDX_W-1:0];
      end

      if (state == S_WWAIT) pwdata <= hwdata;

      if ((state == S_ACCESS) && pready && !pslverr && !pwrite) hrdata <= prdata;

      // Registered APB strobes, computed from the next state so they line up with it.
      pselx   <= ((state_nxt == S_SETUP) || (state_nxt == S_ACCESS)) ? sel_oh : '0;
      penable <= (state_nxt == S_ACCESS);

      if ((state != S_ACCESS) && (state_nxt == S_ACCESS)) begin
        cnt <= '0;
      end else if ((state == S_ACCESS) && !pready && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb3_bridge.sv
// Bench for ahb_apb3_bridge: directed plus randomized AHB transfers, APB slave model, scoreboards.
// Latency: expected wait states derived per transfer from the bridge's timing rules.
// Backpressure: the AHB driver holds each address until hreadyout is seen high.
module tb_ahb_apb3_bridge;

  localparam int          NSLV  = 3;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          SHIFT = 26;
  localparam int          TO    = 16;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    int          k;
    bit          err;
    logic [31:0] rdata;
  } apb_exp_t;

  logic        hclk;
  logic        hreset;
  logic        hsel;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          tests = 0;
  int          fails = 0;
  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];
  logic [31:0] model_hrdata = '0;

  ahb_apb3_bridge #(
    .ADDR_W(32), .DATA_W(32), .NSLV(NSLV), .BASE(BASE), .SLV_SHIFT(SHIFT), .TIMEOUT(TO)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hreadyin(hreadyin), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_reset_outputs();
    chk("rst_pselx", 64'(pselx), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_pwrite", 64'(pwrite), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_hrdata", 64'(hrdata), 64'(0));
    chk("rst_hreadyout", 64'(hreadyout), 64'(1));
    chk("rst_hresp", 64'(hresp), 64'(0));
  endtask

  // AHB response monitor: tracks one data phase at a time, counts wait states.
  bit in_dp = 0;
  int waits = 0;
  int err_waits = 0;
  initial begin
    ahb_exp_t e;
    forever begin
      @(negedge hclk);
      #2;
      if (hreset) begin
        in_dp = 0;
      end else begin
        if (in_dp) begin
          if (!hreadyout) begin
            waits++;
            if (hresp == 2'b01) err_waits++;
          end else begin
            if (ahb_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_response: no transfer expected at %0t", $time);
            end else begin
              e = ahb_q.pop_front();
              chk("hresp", 64'(hresp), e.err ? 64'(1) : 64'(0));
              chk("wait_states", 64'(waits), 64'(e.waits));
              chk("err_wait_cycles", 64'(err_waits), e.err ? 64'(1) : 64'(0));
              if (e.rd && !e.err) model_hrdata = e.rdata;
              chk("hrdata", 64'(hrdata), 64'(model_hrdata));
            end
            in_dp = 0;
          end
        end else begin
          chk("idle_ready_okay", 64'({hreadyout, hresp}), 64'(3'b100));
        end
        if (!in_dp && hreadyout && hsel && hreadyin && htrans[1]) begin
          in_dp = 1;
          waits = 0;
          err_waits = 0;
        end
      end
    end
  end

  // APB slave model: pops the expected request at SETUP, holds pready low for k ACCESS cycles.
  int       acc = 0;
  bit       act = 0;
  apb_exp_t cur;
  initial begin
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;
    cur = '{sel: 3'b0, addr: 32'h0, wr: 1'b0, wdata: 32'h0, k: 0, err: 1'b0, rdata: 32'h0};
    forever begin
      @(negedge hclk);
      if (hreset) begin
        act = 0;
        pready = 1'b0;
        pslverr = 1'b0;
      end else if (pselx != 0 && !penable) begin
        if (apb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_apb_setup: pselx %0b at %0t", pselx, $time);
          act = 0;
        end else begin
          cur = apb_q.pop_front();
          act = 1;
          acc = 0;
          chk("setup_pselx", 64'(pselx), 64'(cur.sel));
          chk("setup_paddr", 64'(paddr), 64'(cur.addr));
          chk("setup_pwrite", 64'(pwrite), 64'(cur.wr));
          if (cur.wr) chk("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
        end
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = $urandom;
      end else if (penable) begin
        acc++;
        chk("access_pselx", 64'(pselx), 64'(cur.sel));
        chk("access_paddr", 64'(paddr), 64'(cur.addr));
        pready = (acc > cur.k);
        pslverr = pready ? cur.err : 1'($urandom);
        prdata = pready ? cur.rdata : $urandom;
      end else begin
        if (act) begin
          chk("access_cycles", 64'(acc), (cur.k < TO) ? 64'(cur.k + 1) : 64'(TO));
          act = 0;
        end
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = $urandom;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!hreadyout && n < 100) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: hreadyout low for %0d cycles", n);
    end
  endtask

  // Issue one transfer and record what the bridge and the APB side must do with it.
  task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] wd,
                      input int k, input bit e, input logic [31:0] rd);
    ahb_exp_t x;
    apb_exp_t p;
    longint   off;
    longint   region;
    bit       hit;
    wait_ready();
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    region = off / (longint'(1) << SHIFT);
    hit = (off >= 0) && (region < NSLV);
    x.rd = !w;
    x.rdata = rd;
    if (!hit) begin
      x.err = 1'b1;
      x.waits = 1;
    end else begin
      p.sel = 3'(1 << region);
      p.addr = a;
      p.wr = w;
      p.wdata = wd;
      p.k = k;
      p.err = e;
      p.rdata = rd;
      apb_q.push_back(p);
      if (k >= TO) begin
        x.err = 1'b1;
        x.waits = (w ? 3 : 2) + TO;
      end else begin
        x.err = e;
        x.waits = (w ? 3 : 2) + k + (e ? 1 : 0);
      end
    end
    ahb_q.push_back(x);
    hsel = 1'b1;
    hreadyin = 1'b1;
    htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    haddr = a;
    hwrite = w;
    @(negedge hclk);
    hwdata = wd;
  endtask

  // Bus patterns that must not start a transfer.
  task automatic idle(input int n);
    wait_ready();
    haddr = 32'h8000_0000 | 32'($urandom_range(0, 255) * 4);
    hwrite = 1'($urandom);
    case ($urandom_range(0, 3))
      0: begin hsel = 1'b0; htrans = 2'b10; end
      1: begin hsel = 1'b1; htrans = 2'b00; end
      2: begin hsel = 1'b1; htrans = 2'b01; end
      default: begin hsel = 1'b1; htrans = 2'b10; hreadyin = 1'b0; end
    endcase
    repeat (n) @(negedge hclk);
    hsel = 1'b0;
    htrans = 2'b00;
    hreadyin = 1'b1;
  endtask

  int klist[9] = '{0, 0, 1, 2, 3, 4, 15, 16, 40};

  initial begin
    logic [31:0] a;
    int          r;
    int          n;
    hreset = 1'b1;
    hsel = 1'b0;
    hreadyin = 1'b1;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr = '0;
    hwdata = '0;
    repeat (2) @(negedge hclk);
    #1;
    check_reset_outputs();
    @(negedge hclk);
    hreset = 1'b0;

    xfer(32'h8400_0010, 1'b0, 32'h0, 0, 1'b0, 32'h0000_00A5);
    xfer(32'h8800_0004, 1'b1, 32'h0000_0024, 0, 1'b0, 32'h0);
    xfer(32'h8000_0100, 1'b1, 32'h1357_9BDF, 4, 1'b1, 32'h0);
    xfer(32'h8C00_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    xfer(32'h8000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678);
    xfer(32'h8400_0020, 1'b0, 32'h0, 40, 1'b0, 32'hDEAD_BEEF);
    xfer(32'h8800_0030, 1'b0, 32'h0, 15, 1'b0, 32'h0F0F_0F0F);
    xfer(32'h8000_0040, 1'b1, 32'hAAAA_5555, 16, 1'b0, 32'h0);
    xfer(32'h7FFF_FFFC, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    idle(3);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + (32'($urandom_range(0, 2)) << SHIFT) + 32'($urandom_range(0, 255) * 4);
      else if (r == 7) a = 32'h8C00_0000 + 32'($urandom_range(0, 255) * 4);
      else if (r == 8) a = 32'($urandom_range(0, 32'h7FFF_FFFF));
      else             a = 32'hF000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
      xfer(a, 1'($urandom), $urandom, klist[$urandom_range(0, 8)],
           ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    // Reset while the APB access is stalled.
    xfer(32'h8000_0040, 1'b0, 32'h0, 40, 1'b0, 32'h0);
    n = 0;
    while (!penable && n < 50) begin
      @(negedge hclk);
      n++;
    end
    chk("reached_access", 64'(penable), 64'(1));
    repeat (2) @(negedge hclk);
    hreset = 1'b1;
    hsel = 1'b0;
    htrans = 2'b00;
    #1;
    check_reset_outputs();
    ahb_q.delete();
    apb_q.delete();
    model_hrdata = '0;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;

    xfer(32'h8400_0008, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_F00D);
    idle(2);
    n = 0;
    while (ahb_q.size() != 0 && n < 100) begin
      @(negedge hclk);
      n++;
    end
    chk("drained", 64'(ahb_q.size()), 64'(0));
    repeat (3) @(negedge hclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
